// File: rtl/conv_pkg.sv
// Shared definitions for the convolution row sequencer.
//   conv_state_e : sequencer FSM states
//   cnt_w()      : bit width needed to hold a count from 0 up to max_count
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    LOAD,
    DRAIN,
    DONE
  } conv_state_e;

  // Never returns less than 1 so degenerate ranges still get a real signal.
  function automatic int cnt_w(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/conv_row_sequencer_if.sv
// Handshake/status bundle for conv_row_sequencer.
//   master : frame controller side, drives input_start/abort/done_ready
//   slave  : sequencer side, drives shift_row_up/param_load/channel_idx/busy/conv_done
interface conv_row_sequencer_if #(
  parameter int CH_W = 1
);
  logic            input_start;
  logic            abort;
  logic            done_ready;
  logic            shift_row_up;
  logic            param_load;
  logic [CH_W-1:0] channel_idx;
  logic            busy;
  logic            conv_done;

  modport master (
    output input_start, abort, done_ready,
    input  shift_row_up, param_load, channel_idx, busy, conv_done
  );

  modport slave (
    input  input_start, abort, done_ready,
    output shift_row_up, param_load, channel_idx, busy, conv_done
  );
endinterface

// File: rtl/conv_cycle_counter.sv
// Loadable down-counter with terminal-count flag, shared by the row,
// parameter-load and drain intervals of the sequencer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : load load_value this edge (wins over dec)
//   load_value   : value to load
//   dec          : decrement by one; saturates at zero so it never wraps
//   tc           : count is zero
module conv_cycle_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/conv_row_sequencer.sv
// Convolution row sequencer: per channel, pulses shift_row_up every
// RAM_SR_DEPTH cycles for NUM_SR_ROWS-1 shifts, reloads parameters for
// P_SR_DEPTH cycles between channels, waits MA_TREE_DEPTH cycles for the
// adder tree after the last channel, then holds conv_done until accepted.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   input_start   : frame start, only looked at in IDLE
//   abort         : drop the frame, back to IDLE with all outputs low
//   done_ready    : consumer accepts conv_done (only looked at in DONE)
//   shift_row_up  : one-cycle row-shift pulse
//   param_load    : parameter shift register reload enable
//   channel_idx   : current channel
//   busy          : not in IDLE
//   conv_done     : frame result valid, held until accepted
// All outputs are registered.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int RAM_SR_DEPTH  = 4,
  parameter int NUM_SR_ROWS   = 4,
  parameter int MA_TREE_DEPTH = 4,
  parameter int P_SR_DEPTH    = 2,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 input_start,
  input  logic                                 abort,
  input  logic                                 done_ready,
  output logic                                 shift_row_up,
  output logic                                 param_load,
  output logic [cnt_w(NUM_CHANNELS-1)-1:0]     channel_idx,
  output logic                                 busy,
  output logic                                 conv_done
);

  localparam int CH_W  = cnt_w(NUM_CHANNELS - 1);
  localparam int ROW_W = cnt_w(NUM_SR_ROWS - 2);
  localparam int CNT_W = cnt_w(max3(RAM_SR_DEPTH - 1, P_SR_DEPTH - 1, MA_TREE_DEPTH - 1));

  // Interval reload values: the counter is loaded on the edge that starts an
  // interval and the action happens on the edge where it is found at zero,
  // so an interval of N cycles loads N-1.
  localparam logic [CNT_W-1:0] ROW_RELOAD   = CNT_W'(RAM_SR_DEPTH - 1);
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(P_SR_DEPTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_RELOAD = CNT_W'(MA_TREE_DEPTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(NUM_SR_ROWS - 2);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CHANNELS - 1);

  conv_state_e      state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [CH_W-1:0]  channel_idx_q, channel_idx_d;
  logic             shift_row_up_q, shift_row_up_d;
  logic             param_load_q, param_load_d;
  logic             busy_q, busy_d;
  logic             conv_done_q, conv_done_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_dec;
  logic             cnt_tc;

  conv_cycle_counter #(
    .WIDTH (CNT_W)
  ) u_interval_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .tc         (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    rows_d         = rows_q;
    channel_idx_d  = channel_idx_q;
    shift_row_up_d = 1'b0;
    param_load_d   = 1'b0;
    conv_done_d    = 1'b0;
    cnt_load       = 1'b0;
    cnt_value      = '0;
    cnt_dec        = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      rows_d        = '0;
      channel_idx_d = '0;
      cnt_load      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (input_start) begin
            state_d       = ROW;
            rows_d        = '0;
            channel_idx_d = '0;
            cnt_load      = 1'b1;
            cnt_value     = ROW_RELOAD;
          end
        end

        ROW: begin
          if (cnt_tc) begin
            shift_row_up_d = 1'b1;
            cnt_load       = 1'b1;
            if (rows_q == LAST_ROW) begin
              rows_d = '0;
              if (channel_idx_q == LAST_CH) begin
                state_d   = DRAIN;
                cnt_value = DRAIN_RELOAD;
              end else begin
                state_d   = LOAD;
                cnt_value = LOAD_RELOAD;
              end
            end else begin
              rows_d    = rows_q + 1'b1;
              cnt_value = ROW_RELOAD;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end

        LOAD: begin
          param_load_d = 1'b1;
          if (cnt_tc) begin
            state_d       = ROW;
            channel_idx_d = channel_idx_q + 1'b1;
            cnt_load      = 1'b1;
            cnt_value     = ROW_RELOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end

        DRAIN: begin
          if (cnt_tc) begin
            state_d     = DONE;
            conv_done_d = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end

        DONE: begin
          if (done_ready) begin
            state_d = IDLE;
          end else begin
            conv_done_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      rows_q         <= '0;
      channel_idx_q  <= '0;
      shift_row_up_q <= 1'b0;
      param_load_q   <= 1'b0;
      busy_q         <= 1'b0;
      conv_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rows_q         <= rows_d;
      channel_idx_q  <= channel_idx_d;
      shift_row_up_q <= shift_row_up_d;
      param_load_q   <= param_load_d;
      busy_q         <= busy_d;
      conv_done_q    <= conv_done_d;
    end
  end

  assign shift_row_up = shift_row_up_q;
  assign param_load   = param_load_q;
  assign channel_idx  = channel_idx_q;
  assign busy         = busy_q;
  assign conv_done    = conv_done_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench for conv_row_sequencer: dut_a uses the defaults (one
// channel), dut_b sequences two channels.
module tb_conv_row_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  conv_row_sequencer_if #(.CH_W(1)) bus_a ();
  conv_row_sequencer_if #(.CH_W(1)) bus_b ();

  conv_row_sequencer dut_a (
    .clock        (clock),
    .reset        (reset),
    .input_start  (bus_a.input_start),
    .abort        (bus_a.abort),
    .done_ready   (bus_a.done_ready),
    .shift_row_up (bus_a.shift_row_up),
    .param_load   (bus_a.param_load),
    .channel_idx  (bus_a.channel_idx),
    .busy         (bus_a.busy),
    .conv_done    (bus_a.conv_done)
  );

  conv_row_sequencer #(
    .RAM_SR_DEPTH  (4),
    .NUM_SR_ROWS   (4),
    .MA_TREE_DEPTH (4),
    .P_SR_DEPTH    (2),
    .NUM_CHANNELS  (2)
  ) dut_b (
    .clock        (clock),
    .reset        (reset),
    .input_start  (bus_b.input_start),
    .abort        (bus_b.abort),
    .done_ready   (bus_b.done_ready),
    .shift_row_up (bus_b.shift_row_up),
    .param_load   (bus_b.param_load),
    .channel_idx  (bus_b.channel_idx),
    .busy         (bus_b.busy),
    .conv_done    (bus_b.conv_done)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input bit sh, input bit dn, input bit by);
    chk({tag, "_shift"}, 32'(bus_a.shift_row_up), 32'(sh));
    chk({tag, "_pload"}, 32'(bus_a.param_load), 32'd0);
    chk({tag, "_ch"},    32'(bus_a.channel_idx), 32'd0);
    chk({tag, "_done"},  32'(bus_a.conv_done), 32'(dn));
    chk({tag, "_busy"},  32'(bus_a.busy), 32'(by));
  endtask

  task automatic check_b(input string tag, input bit sh, input bit pl, input bit ch,
                         input bit dn, input bit by);
    chk({tag, "_shift"}, 32'(bus_b.shift_row_up), 32'(sh));
    chk({tag, "_pload"}, 32'(bus_b.param_load), 32'(pl));
    chk({tag, "_ch"},    32'(bus_b.channel_idx), 32'(ch));
    chk({tag, "_done"},  32'(bus_b.conv_done), 32'(dn));
    chk({tag, "_busy"},  32'(bus_b.busy), 32'(by));
  endtask

  initial begin
    reset             = 1'b1;
    bus_a.input_start = 1'b0;
    bus_a.abort       = 1'b0;
    bus_a.done_ready  = 1'b0;
    bus_b.input_start = 1'b0;
    bus_b.abort       = 1'b0;
    bus_b.done_ready  = 1'b0;

    // Reset state.
    step();
    step();
    check_a("rst_a", 1'b0, 1'b0, 1'b0);
    check_b("rst_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 1: start on the first edge after reset release. input_start is
    // held high all frame and done_ready high during ROW: both must be ignored.
    reset             = 1'b0;
    bus_a.input_start = 1'b1;
    step();
    check_a("f1_e0", 1'b0, 1'b0, 1'b1);
    bus_a.done_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 15) bus_a.done_ready = 1'b0;
      step();
      check_a($sformatf("f1_e%0d", k), (k == 4) || (k == 8) || (k == 12), k == 16, 1'b1);
    end
    // conv_done held while done_ready stays low.
    for (int k = 17; k <= 21; k++) begin
      step();
      check_a($sformatf("f1_hold_e%0d", k), 1'b0, 1'b1, 1'b1);
    end
    // Accept; the start sampled on the exit edge must not begin a frame.
    bus_a.done_ready = 1'b1;
    step();
    check_a("f1_exit", 1'b0, 1'b0, 1'b0);
    bus_a.done_ready  = 1'b0;
    bus_a.input_start = 1'b0;
    step();
    check_a("f1_idle", 1'b0, 1'b0, 1'b0);

    // Frame 2: abort sampled at edge 7, restart at edge 10 with abort also
    // high (abort in IDLE has no effect).
    bus_a.input_start = 1'b1;
    step();
    check_a("f2_e0", 1'b0, 1'b0, 1'b1);
    bus_a.input_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_a($sformatf("f2_e%0d", k), k == 4, 1'b0, 1'b1);
    end
    bus_a.abort = 1'b1;
    step();
    check_a("f2_abort_e7", 1'b0, 1'b0, 1'b0);
    bus_a.abort = 1'b0;
    for (int k = 8; k <= 9; k++) begin
      step();
      check_a($sformatf("f2_e%0d", k), 1'b0, 1'b0, 1'b0);
    end
    bus_a.abort       = 1'b1;
    bus_a.input_start = 1'b1;
    step();
    check_a("f2_e10", 1'b0, 1'b0, 1'b1);
    bus_a.abort       = 1'b0;
    bus_a.input_start = 1'b0;
    for (int k = 11; k <= 26; k++) begin
      step();
      check_a($sformatf("f2_e%0d", k), (k == 14) || (k == 18) || (k == 22), k == 26, 1'b1);
    end
    bus_a.done_ready = 1'b1;
    step();
    check_a("f2_exit", 1'b0, 1'b0, 1'b0);
    bus_a.done_ready = 1'b0;

    // Frame 3: reset sampled at edge 9 mid-frame, restart right after.
    bus_a.input_start = 1'b1;
    step();
    check_a("f3_e0", 1'b0, 1'b0, 1'b1);
    bus_a.input_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_a($sformatf("f3_e%0d", k), (k == 4) || (k == 8), 1'b0, 1'b1);
    end
    reset = 1'b1;
    step();
    check_a("f3_rst_e9", 1'b0, 1'b0, 1'b0);
    reset             = 1'b0;
    bus_a.input_start = 1'b1;
    step();
    check_a("f3_e10", 1'b0, 1'b0, 1'b1);
    bus_a.input_start = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      step();
      check_a($sformatf("f3_e%0d", k), k == 14, 1'b0, 1'b1);
    end
    bus_a.abort = 1'b1;
    step();
    check_a("f3_abort", 1'b0, 1'b0, 1'b0);
    bus_a.abort = 1'b0;

    // Frame 4: two channels with a parameter reload between them.
    bus_b.input_start = 1'b1;
    step();
    check_b("f4_e0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_b.input_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check_b($sformatf("f4_e%0d", k),
              (k == 4) || (k == 8) || (k == 12) || (k == 18) || (k == 22) || (k == 26),
              (k == 13) || (k == 14),
              (k >= 14),
              k == 30,
              1'b1);
    end
    // Abort in DONE outranks done_ready: no further conv_done.
    bus_b.abort      = 1'b1;
    bus_b.done_ready = 1'b1;
    step();
    check_b("f4_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_b.abort      = 1'b0;
    bus_b.done_ready = 1'b0;
    step();
    check_b("f4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_row_sequencer.md
CONV_ROW_SEQUENCER -- requirements
Module: conv_row_sequencer

Interface
REQ-001 SHALL have parameter RAM_SR_DEPTH, 4, cycles per image row shift (D, ≥2).
REQ-002 SHALL have parameter NUM_SR_ROWS, 4, rows of the window shift register (R, ≥2).
REQ-003 SHALL have parameter MA_TREE_DEPTH, 4, adder-tree pipeline latency in cycles (T, ≥1).
REQ-004 SHALL have parameter P_SR_DEPTH, 2, parameter shift-register reload cycles between channels (P, ≥1).
REQ-005 SHALL have parameter NUM_CHANNELS, 1, channels sequenced per frame (C, ≥1).
REQ-006 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port input_start, input, 1, frame start request, sampled only in IDLE.
REQ-009 SHALL have port abort, input, 1, synchronous frame abort.
REQ-010 SHALL have port done_ready, input, 1, consumer accepts conv_done.
REQ-011 SHALL have port shift_row_up, output, 1, one-cycle row-shift pulse.
REQ-012 SHALL have port param_load, output, 1, parameter shift register reload enable.
REQ-013 SHALL have port channel_idx, output, max(1,$clog2(C)), current channel.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port conv_done, output, 1, frame result valid; held until accepted.

Function
REQ-016 SHALL implement states IDLE, ROW, LOAD, DRAIN, DONE; all outputs registered.
REQ-017 Timing notation: edge 0 is the edge sampling input_start=1 in IDLE; "at edge k" means the registered output is high from edge k to edge k+1.
REQ-018 IDLE -> ROW at edge 0; channel_idx=0.
REQ-019 In ROW for channel c starting at edge s, shift_row_up SHALL pulse at edges s+D·n, n=1..R-1; low otherwise.
REQ-020 After the last shift (edge t) of channel c<C-1: LOAD, param_load high at edges t+1..t+P, channel_idx=c+1 at edge t+P, next ROW starts with s=t+P.
REQ-021 After the last shift (edge t) of channel C-1: DRAIN, conv_done high at edge t+T, state DONE.
REQ-022 C=1, defaults: shifts at edges 4, 8, 12; conv_done at 16.
REQ-023 DONE: conv_done held high until done_ready sampled 1, then IDLE and conv_done low at the next edge; done_ready outside DONE ignored.
REQ-024 input_start SHALL be ignored in all states except IDLE, including the edge on which DONE exits.
REQ-025 abort sampled 1 in any non-IDLE state: IDLE at next edge, all outputs 0, channel_idx 0, no conv_done; abort in IDLE has no effect.
REQ-026 Priority: reset > abort > done_ready > normal sequencing.
REQ-027 Counters SHALL be sized by $clog2 of their maximum count and never wrap inside a frame.

Reset
REQ-028 reset sampled 1: state IDLE, all counters 0, shift_row_up=0, param_load=0, channel_idx=0, busy=0, conv_done=0, at that edge, including mid-frame.
REQ-029 First input_start SHALL be honoured on the first edge after reset deasserts.

Structure
REQ-030 State enum and counter-width functions SHALL reside in shared package conv_pkg.
REQ-031 A single sub-module conv_cycle_counter (loadable down-counter, terminal-count flag) SHALL be reused for the row, load and drain intervals.

Verification
REQ-032 Defaults, start pulse -> shift_row_up at 4, 8, 12; conv_done at 16; busy high 0..16.
REQ-033 C=2, P=2 -> shifts 4, 8, 12; param_load 13, 14; channel_idx=1 at 14; shifts 18, 22, 26; conv_done 30.
REQ-034 done_ready held 0 for 5 cycles after conv_done -> conv_done stays high; IDLE one edge after done_ready=1; input_start on that edge ignored.
REQ-035 abort at edge 6 -> all outputs 0 at 7; no shift at 8; new start at 10 gives shifts 14, 18, 22.
REQ-036 reset at edge 9 mid-frame -> all outputs 0 at 9; input_start during busy never restarts sequencing.
